// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: op codes, flag bit positions and FSM states shared by alu_seq
package alu_seq_pkg;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_NOT  = 3'b100;
    localparam logic [2:0] OP_SHL  = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;
    localparam logic [2:0] OP_MUL  = 3'b111;
    localparam int FLG_Z = 0;
    localparam int FLG_N = 1;
    localparam int FLG_C = 2;
    localparam int FLG_V = 3;
    typedef enum logic {ST_IDLE, ST_MUL} state_t;
endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: shift-add multiplier, one multiplier bit per cycle, done pulses when prod is final
module alu_mul_iter #(
    parameter int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 load,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic [2*WIDTH-1:0]   prod,
    output logic                 done
);
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mplier;
    logic [CNT_W-1:0]   cnt;
    // bit 0 is consumed on load, so WIDTH-1 further steps finish the product
    always_ff @(posedge CLK) begin
        if (RST) begin
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
            done   <= 1'b0;
        end else begin
            done <= !load && cnt == CNT_W'(1);
            if (load) begin
                prod   <= b[0] ? {{WIDTH{1'b0}}, a} : '0;
                mcand  <= {{(WIDTH-1){1'b0}}, a, 1'b0};
                mplier <= b >> 1;
                cnt    <= CNT_W'(WIDTH - 1);
            end else if (cnt != '0) begin
                prod   <= prod + (mplier[0] ? mcand : '0);
                mcand  <= mcand << 1;
                mplier <= mplier >> 1;
                cnt    <= cnt - 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with N/Z/C/V flags and START/BUSY/DONE handshake
// Define ALU_SEQ_MUL_EN to build the iterative multiplier; otherwise OP=111 yields zero in one cycle.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [2:0]       OP,
    input  logic             FLGON,
    input  logic [WIDTH-1:0] D1,
    input  logic [WIDTH-1:0] D2,
    output logic [WIDTH-1:0] ALUREG,
    output logic [3:0]       FLG,
    output logic             BUSY,
    output logic             DONE
);
    localparam int SW = $clog2(WIDTH);
    state_t             state, state_nx;
    logic [WIDTH:0]     sum, diff, shl;
    logic [WIDTH-1:0]   res;
    logic [3:0]         flags, mul_flags;
    logic [2:0]         sel;
    logic               c, v, start_mul, mul_done;
    logic [2*WIDTH-1:0] mul_prod;
`ifdef ALU_SEQ_MUL_EN
    assign start_mul = START && !FLGON && OP == OP_MUL && state == ST_IDLE;
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .CLK  (CLK),
        .RST  (RST),
        .load (start_mul),
        .a    (D1),
        .b    (D2),
        .prod (mul_prod),
        .done (mul_done)
    );
`else
    assign start_mul = 1'b0;
    assign mul_done  = 1'b0;
    assign mul_prod  = '0;
`endif
    assign BUSY      = state == ST_MUL;
    assign mul_flags = {1'b0, |mul_prod[2*WIDTH-1:WIDTH], mul_prod[WIDTH-1], mul_prod[WIDTH-1:0] == '0};
    // compare mode reuses the subtract path so its flags match SUB exactly
    always_comb begin
        sel  = FLGON ? OP_SUB : OP;
        sum  = {1'b0, D1} + {1'b0, D2};
        diff = {1'b0, D1} - {1'b0, D2};
        shl  = {1'b0, D1} << D2[SW-1:0];
        res  = '0;
        c    = 1'b0;
        v    = 1'b0;
        case (sel)
            OP_ADD: begin
                res = sum[WIDTH-1:0];
                c   = sum[WIDTH];
                v   = (D1[WIDTH-1] == D2[WIDTH-1]) && (sum[WIDTH-1] != D1[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff[WIDTH-1:0];
                c   = diff[WIDTH];
                v   = (D1[WIDTH-1] != D2[WIDTH-1]) && (diff[WIDTH-1] != D1[WIDTH-1]);
            end
            OP_AND:  res = D1 & D2;
            OP_OR:   res = D1 | D2;
            OP_NOT:  res = ~D1;
            OP_SHL: begin
                res = shl[WIDTH-1:0];
                c   = shl[WIDTH];
            end
            OP_PASS: res = D2;
            default: res = '0;
        endcase
        flags        = '0;
        flags[FLG_Z] = res == '0;
        flags[FLG_N] = res[WIDTH-1];
        flags[FLG_C] = c;
        flags[FLG_V] = v;
    end
    always_comb begin
        state_nx = start_mul ? ST_MUL : (state == ST_MUL && mul_done) ? ST_IDLE : state;
    end
    always_ff @(posedge CLK) begin
        if (RST) begin
            state  <= ST_IDLE;
            ALUREG <= '0;
            FLG    <= '0;
            DONE   <= 1'b0;
        end else begin
            state <= state_nx;
            DONE  <= 1'b0;
            if (state == ST_MUL) begin
                if (mul_done) begin
                    ALUREG <= mul_prod[WIDTH-1:0];
                    FLG    <= mul_flags;
                    DONE   <= 1'b1;
                end
            end else if (START && !start_mul) begin
                if (!FLGON) ALUREG <= res;
                FLG  <= flags;
                DONE <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors, expected results queued at issue and checked whenever DONE pulses
module tb_alu_seq;
    import alu_seq_pkg::*;
    localparam int W = 16;
`ifdef ALU_SEQ_MUL_EN
    localparam int MUL_BUSY = 16;
    localparam int MUL_CYC  = 17;
`else
    localparam int MUL_BUSY = 0;
    localparam int MUL_CYC  = 1;
`endif
    typedef struct packed {
        logic [W-1:0] r;
        logic [3:0]   f;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst, start, flgon;
    logic [2:0]   op;
    logic [W-1:0] d1, d2, alureg;
    logic [3:0]   flg;
    logic         busy, done;
    int           tests = 0, fails = 0, n_done = 0, n_b2b = 0;
    bit           prev_done = 1'b0;
    exp_t         sb[$];

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .CLK    (clk),
        .RST    (rst),
        .START  (start),
        .OP     (op),
        .FLGON  (flgon),
        .D1     (d1),
        .D2     (d2),
        .ALUREG (alureg),
        .FLG    (flg),
        .BUSY   (busy),
        .DONE   (done)
    );

    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            n_done++;
            if (prev_done) n_b2b++;
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got ALUREG=%h FLG=%b, required no DONE", alureg, flg);
            end else begin
                e = sb.pop_front();
                if (alureg !== e.r || flg !== e.f) begin
                    fails++;
                    $display("FAIL result: got ALUREG=%h FLG=%b, required ALUREG=%h FLG=%b", alureg, flg, e.r, e.f);
                end
            end
        end
        prev_done = (done === 1'b1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic fo, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] er, input logic [3:0] ef);
        start = 1'b1;
        op    = o;
        flgon = fo;
        d1    = a;
        d2    = b;
        sb.push_back('{r: er, f: ef});
        @(posedge clk);
        #1;
        start = 1'b0;
        flgon = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && sb.size() != 0; i++) begin
            @(negedge clk);
            #1;
        end
        check("drain_empty", 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    task automatic mul_run(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] er,
                           input logic [3:0] ef, input bit inject);
        int cyc = 0, busy_n = 0;
        bit got = 1'b0;
        issue(OP_MUL, 1'b0, a, b, er, ef);
        while (!got && cyc < 40) begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) busy_n++;
            if (done === 1'b1) got = 1'b1;
            if (inject && cyc == 3) begin
                start = 1'b1;
                op    = OP_ADD;
                d1    = 16'h0001;
                d2    = 16'h0001;
            end else start = 1'b0;
        end
        start = 1'b0;
        check("mul_busy_cycles", 32'(busy_n), 32'(MUL_BUSY));
        check("mul_done_cycle", 32'(cyc), 32'(MUL_CYC));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1);
    end

    initial begin
        int n0, b0;
        rst = 1'b1; start = 1'b1; flgon = 1'b0; op = OP_ADD; d1 = 16'h0001; d2 = 16'h0001;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("rst_alureg", 32'(alureg), 32'd0);
            check("rst_flg", 32'(flg), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done", 32'(done), 32'd0);
        end
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        issue(OP_ADD,  1'b0, 16'h7FFF, 16'h0001, 16'h8000, 4'b1010);
        issue(OP_SUB,  1'b0, 16'h0003, 16'h0005, 16'hFFFE, 4'b0110);
        issue(OP_ADD,  1'b0, 16'hFFFF, 16'h0001, 16'h0000, 4'b0101);
        issue(OP_SUB,  1'b0, 16'h8000, 16'h0001, 16'h7FFF, 4'b1000);
        issue(OP_AND,  1'b0, 16'hF0F0, 16'hFF00, 16'hF000, 4'b0010);
        issue(OP_OR,   1'b0, 16'h00F0, 16'h0F00, 16'h0FF0, 4'b0000);
        issue(OP_PASS, 1'b0, 16'hBEEF, 16'h1234, 16'h1234, 4'b0000);
        drain();
        issue(OP_ADD,  1'b1, 16'h00AA, 16'h00AA, 16'h1234, 4'b0001);
        issue(OP_MUL,  1'b1, 16'h0001, 16'h0002, 16'h1234, 4'b0110);
        drain();
        check("flgon_no_busy", 32'(busy), 32'd0);
`ifdef ALU_SEQ_MUL_EN
        mul_run(16'h0123, 16'h0010, 16'h1230, 4'b0000, 1'b0);
        mul_run(16'h0100, 16'h0100, 16'h0000, 4'b0101, 1'b1);
`else
        mul_run(16'h0123, 16'h0010, 16'h0000, 4'b0001, 1'b0);
        mul_run(16'h0100, 16'h0100, 16'h0000, 4'b0001, 1'b1);
`endif
        drain();
        issue(OP_PASS, 1'b0, 16'h0000, 16'h5A5A, 16'h5A5A, 4'b0000);
        drain();
        n0 = n_done;
`ifdef ALU_SEQ_MUL_EN
        start = 1'b1; op = OP_MUL; flgon = 1'b0; d1 = 16'h0123; d2 = 16'h0010;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("mid_mul_busy", 32'(busy), 32'd1);
`endif
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_alureg", 32'(alureg), 32'd0);
        check("abort_flg", 32'(flg), 32'd0);
        repeat (20) @(negedge clk);
        #1;
        check("abort_no_done", 32'(n_done - n0), 32'd0);
        issue(OP_ADD, 1'b0, 16'h0002, 16'h0003, 16'h0005, 4'b0000);
        drain();
        repeat (2) @(negedge clk);
        #1;
        n0 = n_done;
        b0 = n_b2b;
        issue(OP_SHL, 1'b0, 16'h8001, 16'h0001, 16'h0002, 4'b0100);
        issue(OP_NOT, 1'b0, 16'h00FF, 16'h0000, 16'hFF00, 4'b0010);
        @(negedge clk);
        #1;
        check("b2b_done_count", 32'(n_done - n0), 32'd2);
        check("b2b_consecutive", 32'(n_b2b - b0), 32'd1);
        issue(OP_SHL, 1'b0, 16'h8001, 16'h0000, 16'h8001, 4'b0010);
        issue(OP_SHL, 1'b0, 16'h0001, 16'h000F, 16'h8000, 4'b0010);
        issue(OP_SHL, 1'b0, 16'hC000, 16'h0011, 16'h8000, 4'b0110);
        drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
